cla_adder_pipe: RTL
===================

Name: cla_adder_pipe

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor. Successor to the fixed 4-bit CLA group.
- Operands are split into GROUP-bit lookahead groups. Each pipeline stage resolves GPS groups and registers the carry into the next stage.
- Valid/ready handshake with backpressure, plus subtract mode and carry/overflow/zero flags.
- Sits in the ALU datapath for multi-cycle add/sub/compare and address generation.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of GROUP*GPS.
- GROUP, 4, bits per lookahead group.
- GPS, 2, groups resolved per pipeline stage.
- NSTAGE, WIDTH/(GROUP*GPS) (derived, localparam), pipeline depth = latency in cycles.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all pipeline state.
- in_valid  input  1  operands presented.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; used only when sub=0.
- sub  input  1  1 = A-B (B inverted, carry-in forced 1).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of MSB (sub: 1 = no borrow).
- ovf  output  1  signed overflow.
- zero  output  1  sum == 0.

Behaviour:
- Reset (async, any time, including mid-operation): all stage valid bits, out_valid, sum, cout, ovf and zero go to 0. Data in flight is discarded. in_ready = 1 while reset is deasserted after reset.
- Global advance: adv = !out_valid || out_ready.
  - in_ready = adv (combinational).
  - All stages shift together when adv=1. All stages hold when adv=0.
- Transfer in: in_valid && in_ready. Stage 1 captures:
  - a, b^{WIDTH{sub}}, carry = sub ? 1 : cin.
  - Stage-1 valid = in_valid when adv=1.
- Stage k (1..NSTAGE):
  - Applies GPS cla_group instances to bit slice [(k-1)*GROUP*GPS +: GROUP*GPS], rippling the group carry between them.
  - Writes those sum bits into the in-flight sum register.
  - Registers the carry-out for stage k+1.
  - Upper operand bits travel unchanged; lower sum bits travel unchanged.
  - Bubbles (valid=0) propagate as bubbles. Their data registers may update but are don't-care.
- Latency: exactly NSTAGE cycles from accepted input to out_valid with no stall. Throughput is 1 op/cycle when out_ready stays high.
- Output registers are the final stage:
  - sum and cout registered.
  - ovf = carry into MSB XOR carry out of MSB, registered; that carry is captured in the last stage.
  - zero = running AND of per-slice "slice sum == 0", carried through the stages, registered.
- out_valid holds, and sum/cout/ovf/zero stay stable, while out_ready=0. No result is dropped or duplicated.
- Full pipeline with out_ready=0: in_ready=0. An in_valid asserted then is not accepted, and the upstream must hold it.
- Simultaneous out_ready=1 and in_valid=1 with a full pipeline: output retires and input enters in the same cycle.
- Arithmetic is modulo 2^WIDTH. Each cla_group computes per-bit g=a&b and p=a^b. Group carries use full lookahead, not ripple, inside a group.

Decomposition:
- Shared package cla_pkg:
  - default WIDTH/GROUP/GPS constants.
  - function computing NSTAGE.
  - elaboration check that WIDTH % (GROUP*GPS) == 0.
- Sub-module cla_group (combinational, parameter GROUP):
  - inputs a, b, cin; outputs s, gG, pG, cout, c_msb_in (carry into top bit, for overflow).
  - Generated GPS times per stage.
- Top module holds the stage registers, valid chain and handshake only.

Test Plan:
1. Reset mid-flight:
   - Accept 3 ops, assert reset in cycle 2.
   - out_valid=0, sum=0 immediately; no stale result emerges after release.
2. Defaults, no stall: a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0.
   - After 4 cycles: sum=0, cout=1, ovf=0, zero=1.
3. Signed overflow: a=0x7FFFFFFF, b=1, sub=0 -> sum=0x80000000, ovf=1, cout=0.
4. Subtract: a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0 (borrow), zero=0.
5. Equal subtract: a=b=0x12345678, sub=1 -> sum=0, cout=1, zero=1.
6. Backpressure:
   - Stream 6 back-to-back random ops; hold out_ready=0 for 5 cycles mid-stream.
   - in_ready falls once the pipeline is full; all 6 results emerge in order and match the reference model.
   - Repeat with WIDTH=16, GROUP=4, GPS=1 (NSTAGE=4).

Source files
------------

// File: rtl/cla_pkg.sv
// Shared constants and geometry helpers for the pipelined carry-lookahead adder.
package cla_pkg;

  localparam int CLA_WIDTH = 32;
  localparam int CLA_GROUP = 4;
  localparam int CLA_GPS   = 2;

  function automatic int cla_nstage(input int width, input int group, input int gps);
    return width / (group * gps);
  endfunction

  // The operand must split into a whole number of stages, each at least one slice wide.
  function automatic bit cla_geometry_ok(input int width, input int group, input int gps);
    return (group > 0) && (gps > 0) && (width >= group * gps) && ((width % (group * gps)) == 0);
  endfunction

endpackage

// File: rtl/cla_group.sv
// One GROUP-bit carry-lookahead group: full lookahead carries plus group generate/propagate.
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] s,
  output logic             gG,
  output logic             pG,
  output logic             cout,
  output logic             c_msb_in
);

  logic [GROUP-1:0] g_s;
  logic [GROUP-1:0] p_s;
  logic [GROUP:0]   c_s;
  logic             prop_s;
  logic             term_s;
  logic             gen_s;

  assign g_s = a & b;
  assign p_s = a ^ b;

  // Each carry is a flat sum of generate terms gated by propagate chains, no ripple.
  always_comb begin
    c_s    = {(GROUP + 1){1'b0}};
    prop_s = 1'b0;
    term_s = 1'b0;
    gen_s  = 1'b0;
    for (int i = 0; i <= GROUP; i++) begin
      prop_s = cin;
      for (int m = 0; m < i; m++) begin
        prop_s = prop_s & p_s[m];
      end
      c_s[i] = prop_s;
      for (int j = 0; j < i; j++) begin
        term_s = g_s[j];
        for (int m = j + 1; m < i; m++) begin
          term_s = term_s & p_s[m];
        end
        c_s[i] = c_s[i] | term_s;
      end
    end
    for (int j = 0; j < GROUP; j++) begin
      term_s = g_s[j];
      for (int m = j + 1; m < GROUP; m++) begin
        term_s = term_s & p_s[m];
      end
      gen_s = gen_s | term_s;
    end
  end

  assign s        = p_s ^ c_s[GROUP-1:0];
  assign gG       = gen_s;
  assign pG       = &p_s;
  assign cout     = c_s[GROUP];
  assign c_msb_in = c_s[GROUP-1];

endmodule

// File: rtl/cla_adder_pipe.sv
// Pipelined CLA adder/subtractor: each stage resolves GPS groups of the operand and
// hands its carry, partial sum and running zero flag to the next stage.
module cla_adder_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH,
  parameter int GROUP = CLA_GROUP,
  parameter int GPS   = CLA_GPS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SW     = GROUP * GPS;
  localparam int NSTAGE = cla_nstage(WIDTH, GROUP, GPS);

  if (!cla_geometry_ok(WIDTH, GROUP, GPS)) begin : g_geometry_check
    $error("cla_adder_pipe: WIDTH must be a non-zero multiple of GROUP*GPS");
  end

  logic [NSTAGE-1:0][WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic [NSTAGE-1:0]            c_q, c_d, z_q, z_d, v_q, v_d;
  logic                         ovf_q, ovf_d;

  logic [NSTAGE-1:0][WIDTH-1:0] st_a_s, st_b_s, st_s_s;
  logic [NSTAGE-1:0]            st_c_s, st_z_s, st_v_s;
  logic [NSTAGE-1:0][SW-1:0]    slice_sum_s;
  logic [NSTAGE-1:0]            stage_cout_s;
  logic [NSTAGE-1:0][GPS-1:0]   grp_g_s, grp_p_s, grp_cm_s;
  logic                         adv_s;
  logic                         unused_s;

  assign adv_s = !v_q[NSTAGE-1] || out_ready;

  // Stage 0 works on the port operands directly; later stages on the previous registers.
  always_comb begin
    st_a_s    = a_q;
    st_b_s    = b_q;
    st_s_s    = s_q;
    st_c_s    = c_q;
    st_z_s    = z_q;
    st_v_s    = v_q;
    st_a_s[0] = a;
    st_b_s[0] = b ^ {WIDTH{sub}};
    st_c_s[0] = sub | cin;
    st_s_s[0] = {WIDTH{1'b0}};
    st_z_s[0] = 1'b1;
    st_v_s[0] = in_valid;
    for (int k = 1; k < NSTAGE; k++) begin
      st_a_s[k] = a_q[k-1];
      st_b_s[k] = b_q[k-1];
      st_s_s[k] = s_q[k-1];
      st_c_s[k] = c_q[k-1];
      st_z_s[k] = z_q[k-1];
      st_v_s[k] = v_q[k-1];
    end
  end

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    logic [GPS:0] gc_s;
    assign gc_s[0] = st_c_s[k];
    for (genvar g = 0; g < GPS; g++) begin : g_grp
      localparam int LSB = k * SW + g * GROUP;
      cla_group #(.GROUP(GROUP)) u_grp (
        .a        (st_a_s[k][LSB +: GROUP]),
        .b        (st_b_s[k][LSB +: GROUP]),
        .cin      (gc_s[g]),
        .s        (slice_sum_s[k][g*GROUP +: GROUP]),
        .gG       (grp_g_s[k][g]),
        .pG       (grp_p_s[k][g]),
        .cout     (gc_s[g+1]),
        .c_msb_in (grp_cm_s[k][g])
      );
    end
    assign stage_cout_s[k] = gc_s[GPS];
  end

  // Next state: drop each stage's slice sum into the travelling sum, extend the zero chain.
  always_comb begin
    a_d = st_a_s;
    b_d = st_b_s;
    s_d = st_s_s;
    c_d = stage_cout_s;
    v_d = st_v_s;
    z_d = {NSTAGE{1'b0}};
    for (int k = 0; k < NSTAGE; k++) begin
      s_d[k][k*SW +: SW] = slice_sum_s[k];
      z_d[k]             = st_z_s[k] & (slice_sum_s[k] == {SW{1'b0}});
    end
    ovf_d = grp_cm_s[NSTAGE-1][GPS-1] ^ stage_cout_s[NSTAGE-1];
  end

  // Whole pipeline shifts together on advance and freezes under backpressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      c_q   <= '0;
      z_q   <= '0;
      v_q   <= '0;
      ovf_q <= 1'b0;
    end else if (adv_s) begin
      a_q   <= a_d;
      b_q   <= b_d;
      s_q   <= s_d;
      c_q   <= c_d;
      z_q   <= z_d;
      v_q   <= v_d;
      ovf_q <= ovf_d;
    end
  end

  // Operand copies leaving the last stage and group g/p terms have no consumer here.
  assign unused_s = ^{a_q[NSTAGE-1], b_q[NSTAGE-1], grp_g_s, grp_p_s, grp_cm_s};

  assign in_ready  = adv_s;
  assign out_valid = v_q[NSTAGE-1];
  assign sum       = s_q[NSTAGE-1];
  assign cout      = c_q[NSTAGE-1];
  assign ovf       = ovf_q;
  assign zero      = z_q[NSTAGE-1];

endmodule
